uart_rx_frame: RTL and testbench

- Sequencer directly downstream of the motherboard UART byte receiver.
- On each frame trigger, repeatedly arms the receiver via its start_rx pulse and collects NUM_BYTES consecutive bytes into one frame word.
- Publishes each complete frame atomically and keeps saturating error statistics.
- Consumed by the AXI register bank / ADC sample path.

---
 rtl/uart_rx_frame.sv | 142 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - frame sequencer that gathers NUM_BYTES UART bytes into one frame word
//
// Each trigger arms the downstream UART receiver once per byte. The collected
// bytes are published as one word only after the whole frame is good.
// Saturating counters record aborted frames.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   trigger        single-cycle request to capture one frame
//   byte_valid     receiver: byte received with good parity (sticky until re-armed)
//   data_corrupt   receiver: parity failure (sticky until re-armed)
//   rx_timeout     receiver: no start bit seen (sticky until re-armed)
//   rx_byte        receiver data, meaningful while byte_valid=1
//   clr_counts     synchronous clear of error counters and trig_overrun
//   start_rx       one-cycle pulse that arms the receiver
//   busy           frame in progress
//   frame_data     last good frame, first received byte in the MSBs
//   frame_valid    one-cycle pulse when frame_data updates
//   frame_error    one-cycle pulse when a frame is aborted
//   corrupt_count  frames aborted by parity failure (saturating)
//   timeout_count  frames aborted by receiver timeout (saturating)
//   trig_overrun   sticky: trigger arrived while busy
module uart_rx_frame #(
   parameter int NUM_BYTES = 4,
   parameter int CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   trigger,
   input  logic                   byte_valid,
   input  logic                   data_corrupt,
   input  logic                   rx_timeout,
   input  logic [7:0]             rx_byte,
   input  logic                   clr_counts,
   output logic                   start_rx,
   output logic                   busy,
   output logic [8*NUM_BYTES-1:0] frame_data,
   output logic                   frame_valid,
   output logic                   frame_error,
   output logic [CNT_W-1:0]       corrupt_count,
   output logic [CNT_W-1:0]       timeout_count,
   output logic                   trig_overrun
);

   localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int FRAME_W = 8 * NUM_BYTES;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   byte_idx;
   logic [FRAME_W-1:0] buffer;
   logic [FRAME_W-1:0] buffer_next;
   logic               corrupt_hit;
   logic               timeout_hit;

   // Buffer with the current byte merged into its slot; slot 0 is the MSB byte.
   always_comb begin
      buffer_next = buffer;
      buffer_next[FRAME_W - 8 - 8 * int'(byte_idx) +: 8] = rx_byte;
   end

   // Flags are only meaningful in WAIT; in ARM they are still the previous byte's.
   assign corrupt_hit = (state == WAIT) && data_corrupt;
   assign timeout_hit = (state == WAIT) && !data_corrupt && rx_timeout;

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         byte_idx      <= '0;
         buffer        <= '0;
         start_rx      <= 1'b0;
         frame_data    <= '0;
         frame_valid   <= 1'b0;
         frame_error   <= 1'b0;
         corrupt_count <= '0;
         timeout_count <= '0;
         trig_overrun  <= 1'b0;
      end else begin
         start_rx    <= 1'b0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;

         case (state)
            IDLE: begin
               if (trigger) begin
                  byte_idx <= '0;
                  start_rx <= 1'b1;
                  state    <= ARM;
               end
            end
            ARM: begin
               state <= WAIT;
            end
            WAIT: begin
               if (data_corrupt || rx_timeout) begin
                  // Partial buffer is dropped; frame_data keeps the last good frame.
                  frame_error <= 1'b1;
                  state       <= IDLE;
               end else if (byte_valid) begin
                  buffer <= buffer_next;
                  if (byte_idx == LAST_IDX) begin
                     frame_data  <= buffer_next;
                     frame_valid <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     start_rx <= 1'b1;
                     state    <= ARM;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // Statistics; a clear wins over any same-cycle increment or set.
         if (clr_counts) begin
            corrupt_count <= '0;
            timeout_count <= '0;
            trig_overrun  <= 1'b0;
         end else begin
            if (corrupt_hit && (corrupt_count != CNT_MAX))
               corrupt_count <= corrupt_count + 1'b1;
            if (timeout_hit && (timeout_count != CNT_MAX))
               timeout_count <= timeout_count + 1'b1;
            if (trigger && (state != IDLE))
               trig_overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - randomized self-checking bench for uart_rx_frame
module tb_uart_rx_frame;

   localparam int NB   = 4;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   localparam int K_GOOD    = 0;
   localparam int K_CORRUPT = 1;
   localparam int K_TIMEOUT = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         dly;
      bit         clr;
   } resp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            trigger = 1'b0;
   logic            byte_valid = 1'b0;
   logic            data_corrupt = 1'b0;
   logic            rx_timeout = 1'b0;
   logic [7:0]      rx_byte = 8'h00;
   logic            clr_main = 1'b0;
   logic            clr_rx = 1'b0;
   logic            clr_counts;
   logic            start_rx;
   logic            busy;
   logic [8*NB-1:0] frame_data;
   logic            frame_valid;
   logic            frame_error;
   logic [CW-1:0]   corrupt_count;
   logic [CW-1:0]   timeout_count;
   logic            trig_overrun;

   assign clr_counts = clr_main | clr_rx;

   uart_rx_frame #(.NUM_BYTES(NB), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .trigger       (trigger),
      .byte_valid    (byte_valid),
      .data_corrupt  (data_corrupt),
      .rx_timeout    (rx_timeout),
      .rx_byte       (rx_byte),
      .clr_counts    (clr_counts),
      .start_rx      (start_rx),
      .busy          (busy),
      .frame_data    (frame_data),
      .frame_valid   (frame_valid),
      .frame_error   (frame_error),
      .corrupt_count (corrupt_count),
      .timeout_count (timeout_count),
      .trig_overrun  (trig_overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference state
   resp_t           plan[$];
   resp_t           rq[$];
   logic [8*NB-1:0] exp_fd = '0;
   int              exp_corrupt = 0;
   int              exp_timeout = 0;
   bit              exp_ovr = 1'b0;

   // Pulse monitor
   int n_start = 0;
   int n_fv    = 0;
   int n_fe    = 0;
   bit both_hi = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (start_rx) n_start++;
         if (frame_valid) n_fv++;
         if (frame_error) n_fe++;
         if (frame_valid && frame_error) both_hi = 1'b1;
      end
   end

   // Receiver model: flags stay up through the ARM cycle, clear one edge after
   // start_rx, then the planned response appears after dly cycles.
   initial begin
      int    phase;
      int    cnt;
      resp_t cur;
      phase = 0;
      cnt   = 0;
      forever begin
         @(negedge clk);
         clr_rx = 1'b0;
         if (phase == 1) begin
            byte_valid   = 1'b0;
            data_corrupt = 1'b0;
            rx_timeout   = 1'b0;
            if (rq.size() > 0) begin
               cur = rq.pop_front();
            end else begin
               cur.kind = K_TIMEOUT;
               cur.data = 8'h00;
               cur.dly  = 0;
               cur.clr  = 1'b0;
            end
            cnt   = cur.dly;
            phase = 2;
         end
         if (phase == 2) begin
            if (cnt == 0) begin
               rx_byte      = cur.data;
               byte_valid   = (cur.kind == K_GOOD);
               data_corrupt = (cur.kind == K_CORRUPT);
               rx_timeout   = (cur.kind == K_TIMEOUT);
               clr_rx       = cur.clr;
               phase        = 0;
            end else begin
               cnt--;
            end
         end
         if (start_rx) phase = 1;
      end
   end

   task automatic add(input int kind, input logic [7:0] data, input int dly, input bit clr);
      resp_t r;
      r.kind = kind;
      r.data = data;
      r.dly  = dly;
      r.clr  = clr;
      plan.push_back(r);
   endtask

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic run_frame(input string tag, input bit mid_trig);
      int              nstart;
      bit              aborted;
      logic [8*NB-1:0] acc;
      int              n;
      nstart  = 0;
      aborted = 1'b0;
      acc     = '0;
      if (mid_trig) exp_ovr = 1'b1;
      foreach (plan[i]) begin
         if (!aborted && nstart < NB) begin
            nstart++;
            if (plan[i].kind == K_CORRUPT) begin
               exp_corrupt = sat_inc(exp_corrupt);
               aborted = 1'b1;
            end else if (plan[i].kind == K_TIMEOUT) begin
               exp_timeout = sat_inc(exp_timeout);
               aborted = 1'b1;
            end else begin
               acc = {acc[8*NB-9:0], plan[i].data};
            end
            if (plan[i].clr) begin
               exp_corrupt = 0;
               exp_timeout = 0;
               exp_ovr     = 1'b0;
            end
         end
      end
      if (!aborted) exp_fd = acc;
      rq = plan;
      plan.delete();

      n_start = 0;
      n_fv    = 0;
      n_fe    = 0;
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      chk({tag, "_busy_hi"}, busy, 1'b1);
      if (mid_trig) begin
         trigger = 1'b1;
         @(negedge clk);
         trigger = 1'b0;
      end
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done"}, (n < 300), 1'b1);
      @(negedge clk);
      chk({tag, "_busy_lo"}, busy, 1'b0);
      chk({tag, "_starts"}, n_start, nstart);
      chk({tag, "_fv"}, n_fv, aborted ? 0 : 1);
      chk({tag, "_fe"}, n_fe, aborted ? 1 : 0);
      chk({tag, "_fdata"}, frame_data, exp_fd);
      chk({tag, "_ccnt"}, corrupt_count, exp_corrupt);
      chk({tag, "_tcnt"}, timeout_count, exp_timeout);
      chk({tag, "_ovr"}, trig_overrun, exp_ovr);
   endtask

   task automatic clear_main();
      clr_main = 1'b1;
      @(negedge clk);
      clr_main = 1'b0;
      exp_corrupt = 0;
      exp_timeout = 0;
      exp_ovr     = 1'b0;
      @(negedge clk);
      chk("clr_ccnt", corrupt_count, 0);
      chk("clr_tcnt", timeout_count, 0);
      chk("clr_ovr", trig_overrun, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_start", start_rx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fdata", frame_data, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_fv", frame_valid, 0);
      chk("idle_fe", frame_error, 0);
      chk("idle_ccnt", corrupt_count, 0);
      chk("idle_tcnt", timeout_count, 0);
      chk("idle_ovr", trig_overrun, 0);

      // Nominal frame with stale flags held through every ARM cycle
      add(K_GOOD, 8'hDE, 0, 0);
      add(K_GOOD, 8'hAD, 2, 0);
      add(K_GOOD, 8'hBE, 0, 0);
      add(K_GOOD, 8'hEF, 1, 0);
      run_frame("nominal", 1'b0);
      chk("nominal_value", frame_data, 32'hDEADBEEF);

      // Parity abort on the second byte
      add(K_GOOD, 8'h11, 0, 0);
      add(K_CORRUPT, 8'h22, 1, 0);
      run_frame("parity", 1'b0);
      chk("parity_keep", frame_data, 32'hDEADBEEF);

      // Timeout on the first byte
      add(K_TIMEOUT, 8'h33, 0, 0);
      run_frame("timeout", 1'b0);

      // Overrun while busy; frame still completes
      add(K_GOOD, 8'h01, 1, 0);
      add(K_GOOD, 8'h23, 0, 0);
      add(K_GOOD, 8'h45, 3, 0);
      add(K_GOOD, 8'h67, 0, 0);
      run_frame("overrun", 1'b1);

      // Clear coincident with a corrupt abort
      add(K_GOOD, 8'h89, 0, 0);
      add(K_CORRUPT, 8'hAB, 2, 1);
      run_frame("clr_abort", 1'b0);

      // Randomized frames
      for (int f = 0; f < 40; f++) begin
         for (int b = 0; b < NB; b++) begin
            int r;
            int k;
            r = $urandom_range(0, 99);
            k = (r < 10) ? K_CORRUPT : (r < 20) ? K_TIMEOUT : K_GOOD;
            add(k, 8'($urandom), $urandom_range(0, 3), 1'b0);
            if (k != K_GOOD) break;
         end
         run_frame("rand", ($urandom_range(0, 4) == 0));
      end

      // Saturation: five consecutive timeouts on a 2-bit counter
      clear_main();
      for (int t = 0; t < 5; t++) begin
         add(K_TIMEOUT, 8'h00, $urandom_range(0, 2), 1'b0);
         run_frame("sat", 1'b0);
      end
      chk("sat_value", timeout_count, 3);

      // Reset asserted while waiting for a byte
      add(K_GOOD, 8'h5A, 20, 0);
      rq = plan;
      plan.delete();
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_start", start_rx, 0);
      chk("mid_rst_fdata", frame_data, 0);
      chk("mid_rst_fv", frame_valid, 0);
      chk("mid_rst_fe", frame_error, 0);
      chk("mid_rst_tcnt", timeout_count, 0);
      chk("mid_rst_ccnt", corrupt_count, 0);
      chk("mid_rst_ovr", trig_overrun, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_fdata", frame_data, 0);

      chk("fv_fe_exclusive", both_hi, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
